// File: rtl/usb_defs.sv
// Shared definitions for the USB packet buffer arbiter slice.
// Holds the default buffer size and the state encodings of the ownership
// and arbiter FSMs. The state machines use plain localparam constants so
// older tools that lack enum support can read the same encodings.
package usb_defs;

    // Packet buffer size in bytes; must be a power of two and at least 8.
    localparam int USB_PACKET_BUFFER_SIZE = 1024;

    // Packet ownership: which side currently owns the buffer contents.
    localparam logic [0:0] OWN_USB = 1'b0;
    localparam logic [0:0] OWN_CPU = 1'b1;

    // CPU access arbiter.
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_ACK  = 1'b1;

endpackage

// File: rtl/usb_packet_length_tracker.sv
// Tracks the length, in words, of the packet being received.
// max_words follows the highest (address + 1) over accepted receiver writes
// and is latched into packet_word_count when the packet completes.
//
// Ports:
//   clock48, reset       clock and synchronous active-high reset
//   write_accept         a receiver write is being accepted this cycle
//   write_address        word address of that write
//   capture              packet complete: latch the length (write included)
//   clear                buffer released: restart the length at zero
//   packet_word_count    length of the last completed packet
module usb_packet_length_tracker
    import usb_defs::*;
#(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock48,
    input  logic                     reset,
    input  logic                     write_accept,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic                     capture,
    input  logic                     clear,
    output logic [ADDRESS_WIDTH:0]   packet_word_count
);

    logic [ADDRESS_WIDTH:0] max_words_q, max_words_d;
    logic [ADDRESS_WIDTH:0] count_q, count_d;
    logic [ADDRESS_WIDTH:0] write_end;

    // One extra bit lets the top address map to 2^ADDRESS_WIDTH words.
    assign write_end = {1'b0, write_address} + {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        max_words_d = max_words_q;
        if (write_accept && (write_end > max_words_q)) begin
            max_words_d = write_end;
        end
        count_d = count_q;
        // Capture sees a write landing in the same cycle.
        if (capture) begin
            count_d = max_words_d;
        end
        if (clear) begin
            max_words_d = '0;
        end
    end

    always_ff @(posedge clock48) begin
        if (reset) begin
            max_words_q <= '0;
            count_q     <= '0;
        end else begin
            max_words_q <= max_words_d;
            count_q     <= count_d;
        end
    end

    assign packet_word_count = count_q;

endmodule

// File: rtl/usb_packet_buffer_arbiter.sv
// Owner of the single-port USB packet buffer RAM (word wide, 1-cycle read).
// Shares the RAM between the USB receiver write port and the CPU load/store
// port, runs the usb_packet_ready ownership handshake and records the word
// length of each received packet.
//
// Ports:
//   clock48, reset                 clock, synchronous active-high reset
//   usb_write/address/write_value  receiver word writes (accepted in OWN_USB)
//   usb_packet_done                receiver finished a packet
//   usb_packet_ready               buffer owned by the CPU
//   cpu_request/write/address/     CPU access, held until cpu_ready
//   cpu_write_value
//   cpu_read_value, cpu_ready      load data and one-cycle completion pulse
//   cpu_release                    CPU hands the buffer back to the receiver
//   packet_word_count              length of the last completed packet
//   overrun_count                  dropped receiver writes
//   mem_*                          RAM interface
//
// Build option: define USB_OVERRUN_COUNT_EN to build the saturating
// overrun counter; otherwise overrun_count is tied to zero.
module usb_packet_buffer_arbiter #(
    parameter int  USB_PACKET_BUFFER_SIZE = usb_defs::USB_PACKET_BUFFER_SIZE,
    localparam int ADDRESS_WIDTH          = $clog2(USB_PACKET_BUFFER_SIZE / 4)
) (
    input  logic                     clock48,
    input  logic                     reset,
    input  logic                     usb_write,
    input  logic [ADDRESS_WIDTH-1:0] usb_address,
    input  logic [31:0]              usb_write_value,
    input  logic                     usb_packet_done,
    output logic                     usb_packet_ready,
    input  logic                     cpu_request,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [31:0]              cpu_write_value,
    output logic [31:0]              cpu_read_value,
    output logic                     cpu_ready,
    input  logic                     cpu_release,
    output logic [ADDRESS_WIDTH:0]   packet_word_count,
    output logic [7:0]               overrun_count,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write,
    output logic [31:0]              mem_write_value,
    input  logic [31:0]              mem_read_value
);

    import usb_defs::*;

    logic [0:0]               own_q, own_d;
    logic [0:0]               arb_q, arb_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q;
    logic                     usb_accept;
    logic                     cpu_grant;
    logic                     capture;
    logic                     clear;

    // Reset gates the strobes so nothing reaches the RAM while in reset.
    assign usb_accept = usb_write && (own_q == OWN_USB) && !reset;
    assign cpu_grant  = cpu_request && (arb_q == ARB_IDLE) && !usb_accept && !reset;
    assign capture    = usb_packet_done && (own_q == OWN_USB);
    assign clear      = cpu_release && (own_q == OWN_CPU);

    always_comb begin
        own_d = own_q;
        if (capture) begin
            own_d = OWN_CPU;
        end else if (clear) begin
            own_d = OWN_USB;
        end
        arb_d = cpu_grant ? ARB_ACK : ARB_IDLE;
    end

    // Receiver writes win the RAM; idle cycles keep the last address.
    always_comb begin
        mem_write       = 1'b0;
        mem_address     = mem_address_q;
        mem_write_value = '0;
        if (usb_accept) begin
            mem_write       = 1'b1;
            mem_address     = usb_address;
            mem_write_value = usb_write_value;
        end else if (cpu_grant) begin
            mem_write       = cpu_write;
            mem_address     = cpu_address;
            mem_write_value = cpu_write_value;
        end
    end

    always_ff @(posedge clock48) begin
        if (reset) begin
            own_q         <= OWN_USB;
            arb_q         <= ARB_IDLE;
            mem_address_q <= '0;
        end else begin
            own_q         <= own_d;
            arb_q         <= arb_d;
            mem_address_q <= mem_address;
        end
    end

    // Read data belongs to the address granted last cycle, so a receiver
    // write during ARB_ACK cannot disturb it. Reset abandons the access.
    assign cpu_ready        = (arb_q == ARB_ACK) && !reset;
    assign cpu_read_value   = mem_read_value;
    assign usb_packet_ready = (own_q == OWN_CPU);

    usb_packet_length_tracker #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_length_tracker (
        .clock48           (clock48),
        .reset             (reset),
        .write_accept      (usb_accept),
        .write_address     (usb_address),
        .capture           (capture),
        .clear             (clear),
        .packet_word_count (packet_word_count)
    );

`ifdef USB_OVERRUN_COUNT_EN
    logic [7:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (usb_write && (own_q == OWN_CPU) && (overrun_q != 8'hff)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clock48) begin
        if (reset) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_count = overrun_q;
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_usb_packet_buffer_arbiter.sv
module tb_usb_packet_buffer_arbiter;

    localparam int AW = 8;
`ifdef USB_OVERRUN_COUNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clock48 = 1'b0;
    logic          reset;
    logic          usb_write;
    logic [AW-1:0] usb_address;
    logic [31:0]   usb_write_value;
    logic          usb_packet_done;
    logic          usb_packet_ready;
    logic          cpu_request;
    logic          cpu_write;
    logic [AW-1:0] cpu_address;
    logic [31:0]   cpu_write_value;
    logic [31:0]   cpu_read_value;
    logic          cpu_ready;
    logic          cpu_release;
    logic [AW:0]   packet_word_count;
    logic [7:0]    overrun_count;
    logic [AW-1:0] mem_address;
    logic          mem_write;
    logic [31:0]   mem_write_value;
    logic [31:0]   mem_read_value;

    always #5 clock48 = ~clock48;

    usb_packet_buffer_arbiter dut (
        .clock48           (clock48),
        .reset             (reset),
        .usb_write         (usb_write),
        .usb_address       (usb_address),
        .usb_write_value   (usb_write_value),
        .usb_packet_done   (usb_packet_done),
        .usb_packet_ready  (usb_packet_ready),
        .cpu_request       (cpu_request),
        .cpu_write         (cpu_write),
        .cpu_address       (cpu_address),
        .cpu_write_value   (cpu_write_value),
        .cpu_read_value    (cpu_read_value),
        .cpu_ready         (cpu_ready),
        .cpu_release       (cpu_release),
        .packet_word_count (packet_word_count),
        .overrun_count     (overrun_count),
        .mem_address       (mem_address),
        .mem_write         (mem_write),
        .mem_write_value   (mem_write_value),
        .mem_read_value    (mem_read_value)
    );

    // Synchronous single-port RAM attached to the DUT.
    logic [31:0] ram [256];
    logic        tb_clear;
    always @(posedge clock48) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (mem_write) begin
            ram[mem_address] <= mem_write_value;
        end
        mem_read_value <= ram[mem_address];
    end

    // Reference model: buffer contents, ownership and counters.
    logic [31:0] m_ram [256];
    bit          m_ready;
    int          m_max, m_cnt, m_ovr;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply model rules to the inputs of this cycle, advance one clock, check.
    task automatic cyc();
        bit acc;
        #1;
        acc = usb_write && !m_ready && !reset;
        if (reset) begin
            m_ready = 0; m_max = 0; m_cnt = 0; m_ovr = 0;
        end else begin
            if (acc) begin
                chk("usb_mem_write", {31'd0, mem_write}, 32'd1);
                chk("usb_mem_addr", {24'd0, mem_address}, {24'd0, usb_address});
                chk("usb_mem_data", mem_write_value, usb_write_value);
                m_ram[usb_address] = usb_write_value;
                if (int'(usb_address) + 1 > m_max) m_max = int'(usb_address) + 1;
            end
            if (usb_write && m_ready) begin
                if (!cpu_request) chk("drop_no_write", {31'd0, mem_write}, 32'd0);
                if (OVR_EN && m_ovr < 255) m_ovr++;
            end
            if (!m_ready && usb_packet_done) begin
                m_ready = 1; m_cnt = m_max;
            end else if (m_ready && cpu_release) begin
                m_ready = 0; m_max = 0;
            end
        end
        @(posedge clock48);
        #1;
        chk("ready", {31'd0, usb_packet_ready}, {31'd0, m_ready});
        chk("word_count", {23'd0, packet_word_count}, m_cnt);
        chk("overrun", {24'd0, overrun_count}, m_ovr);
    endtask

    task automatic usb_wr(input int addr, input logic [31:0] val);
        usb_write = 1; usb_address = AW'(addr); usb_write_value = val;
        cyc();
        usb_write = 0;
    endtask

    task automatic pulse(input bit done, input bit rel);
        usb_packet_done = done; cpu_release = rel;
        cyc();
        usb_packet_done = 0; cpu_release = 0;
    endtask

    // One CPU access; force_addr >= 0 collides a receiver write on cycle 0.
    task automatic cpu_access(input bit wr, input int addr, input logic [31:0] val,
                              input int collide_pct, input int force_addr, output int lat);
        bit          granted = 0;
        bit          done    = 0;
        bit          acc;
        logic [31:0] exp_rd  = '0;
        lat = 0;
        cpu_request = 1; cpu_write = wr; cpu_address = AW'(addr); cpu_write_value = val;
        for (int i = 0; i < 40 && !done; i++) begin
            usb_write = 0;
            if (i == 0 && force_addr >= 0) begin
                usb_write = 1; usb_address = AW'(force_addr); usb_write_value = $urandom;
            end else if (int'($urandom_range(99)) < collide_pct) begin
                usb_write = 1; usb_address = AW'($urandom); usb_write_value = $urandom;
            end
            #1;
            acc = usb_write && !m_ready;
            if (!acc) begin
                granted = 1;
                chk("grant_mem_write", {31'd0, mem_write}, {31'd0, wr});
                chk("grant_mem_addr", {24'd0, mem_address}, addr);
                if (wr) m_ram[addr] = val;
                else exp_rd = m_ram[addr];
            end
            cyc();
            usb_write = 0;
            lat++;
            if (granted) begin
                chk("cpu_ready", {31'd0, cpu_ready}, 32'd1);
                if (!wr) chk("cpu_load", cpu_read_value, exp_rd);
                done = 1;
            end else begin
                chk("cpu_wait", {31'd0, cpu_ready}, 32'd0);
            end
        end
        if (!done) chk("cpu_timeout", 32'd0, 32'd1);
        cpu_request = 0;
        if (int'($urandom_range(99)) < collide_pct) begin
            usb_write = 1; usb_address = AW'($urandom); usb_write_value = $urandom;
        end
        cyc();
        usb_write = 0;
        chk("ready_pulse_end", {31'd0, cpu_ready}, 32'd0);
    endtask

    initial begin
        int lat;
        int r;
        reset = 1; tb_clear = 1;
        usb_write = 0; usb_address = '0; usb_write_value = '0; usb_packet_done = 0;
        cpu_request = 0; cpu_write = 0; cpu_address = '0; cpu_write_value = '0;
        cpu_release = 0;
        for (int i = 0; i < 256; i++) m_ram[i] = '0;
        m_ready = 0; m_max = 0; m_cnt = 0; m_ovr = 0;
        repeat (2) @(posedge clock48);
        #1;
        tb_clear = 0;
        chk("rst_ready", {31'd0, usb_packet_ready}, 32'd0);
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_count", {23'd0, packet_word_count}, 32'd0);
        chk("rst_overrun", {24'd0, overrun_count}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        reset = 0;

        // Five-word packet, then hand-over.
        for (int a = 0; a < 5; a++) usb_wr(a, 32'hA000_0000 + a);
        pulse(1, 0);
        chk("pkt5_count", {23'd0, packet_word_count}, 32'd5);
        for (int a = 0; a < 5; a++) cpu_access(0, a, '0, 0, -1, lat);
        cpu_access(0, 3, '0, 0, -1, lat);
        chk("load_latency", lat, 32'd1);

        // Dropped writes while the CPU owns the buffer.
        for (int k = 0; k < 3; k++) usb_wr(0, 32'hDEAD_BEEF);
        chk("overrun3", {24'd0, overrun_count}, OVR_EN ? 32'd3 : 32'd0);
        cpu_access(0, 0, '0, 0, -1, lat);

        // Release, then a two-word packet.
        pulse(0, 1);
        usb_wr(0, 32'h1111_0000);
        usb_wr(1, 32'h1111_0001);
        pulse(1, 0);
        chk("pkt2_count", {23'd0, packet_word_count}, 32'd2);
        pulse(0, 1);

        // Collision: receiver write to 7 in the request cycle.
        cpu_access(1, 2, 32'h5555_AAAA, 0, 7, lat);
        chk("collide_latency", lat, 32'd2);
        cpu_access(0, 7, '0, 0, -1, lat);
        cpu_access(0, 2, '0, 0, -1, lat);

        // Done together with release: only the current state matters.
        pulse(1, 0);
        chk("pkt8_count", {23'd0, packet_word_count}, 32'd8);
        pulse(1, 1);
        chk("done_rel_ready", {31'd0, usb_packet_ready}, 32'd0);
        chk("done_rel_count", {23'd0, packet_word_count}, 32'd8);

        // Reset while the load is in ARB_ACK.
        cpu_request = 1; cpu_write = 0; cpu_address = 8'd3;
        cyc();
        reset = 1; cpu_request = 0;
        #1;
        chk("rst_abandon_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_abandon_mem_write", {31'd0, mem_write}, 32'd0);
        cyc();
        reset = 0;
        #1;
        chk("post_rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("post_rst_mem_write", {31'd0, mem_write}, 32'd0);

        // Top address gives the full 2^AW word count.
        usb_wr(255, 32'hFFFF_0000);
        pulse(1, 0);
        chk("max_count", {23'd0, packet_word_count}, 32'd256);

        // Overrun saturation.
        for (int k = 0; k < 260; k++) usb_wr(k, $urandom);
        chk("overrun_sat", {24'd0, overrun_count}, OVR_EN ? 32'd255 : 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(9));
            if (r < 4) usb_wr(int'($urandom_range(255)), $urandom);
            else if (r == 4) pulse(1, 0);
            else if (r == 5) pulse(0, 1);
            else if (r == 6) pulse(1, 1);
            else cpu_access(1'($urandom), int'($urandom_range(255)), $urandom, 40, -1, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
